pwm_duty_ramp: RTL and testbench

//   Upstream stage of the PWM generator. Takes a target duty-cycle word and

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_step_prescaler.sv | 36 +++
 rtl/pwm_duty_ramp.sv | 138 +++++++++++++
 tb/tb_pwm_duty_ramp.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator blocks: the ramp state encoding
// and the default duty word width used by both the ramp stage and the core.
package pwm_pkg;

   localparam int PWM_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } ramp_state_t;

   // True for the states in which the duty value is still moving.
   function automatic logic ramp_active(input ramp_state_t s);
      return (s != IDLE);
   endfunction

endpackage

// File: rtl/pwm_step_prescaler.sv
// Counts period_end ticks modulo STEP_DIV and flags the tick that completes
// a full group, which is the tick on which the ramp takes one step.
// The counter is held at zero while clear is high; clear wins over tick.
module pwm_step_prescaler #(
   parameter int STEP_DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic step_strobe
);

   localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] div_cnt;

   assign step_strobe = tick && !clear && (div_cnt == LAST);

   // Period counter: wraps to zero on the stepping tick, cleared while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (clear) begin
         div_cnt <= '0;
      end else if (tick) begin
         if (div_cnt == LAST) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slew-rate-limited duty value for the PWM core. duty_o walks toward the
// captured target by STEP once every STEP_DIV period_end pulses, clamping at
// the target, and only ever changes on a period boundary.
// Optional feature macro: PWM_RAMP_SNAP_EN adds snap_i, which makes the next
// period_end after a snapping load jump straight to the new target.
//
// Handshake: target_load is a single-cycle strobe with no back-pressure;
// target_i is captured on the edge where target_load is high, and a later
// load simply overwrites the previous target. period_end is a single-cycle
// pulse from the core; duty_upd is a single-cycle pulse on every duty change.
module pwm_duty_ramp
   import pwm_pkg::*;
#(
   parameter int WIDTH    = PWM_WIDTH_DEFAULT,
   parameter int STEP     = 1,
   parameter int STEP_DIV = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] target_i,
   input  logic             target_load,
   input  logic             period_end,
`ifdef PWM_RAMP_SNAP_EN
   input  logic             snap_i,
`endif
   output logic [WIDTH-1:0] duty_o,
   output logic             duty_upd,
   output logic             busy,
   output ramp_state_t      state_dbg
);

   localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

   ramp_state_t      state;
   ramp_state_t      state_d;
   logic [WIDTH-1:0] target_q;
   logic [WIDTH-1:0] duty_d;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   dn_diff;
   logic             step_strobe;
   logic             snap_fire;
   logic             pre_clear;
   logic             pre_tick;

   assign state_dbg = state;

`ifdef PWM_RAMP_SNAP_EN
   logic snap_pend;

   assign snap_fire = snap_pend && period_end;

   // A snapping load arms the bypass; a normal load disarms it; the next
   // period_end consumes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_pend <= 1'b0;
      end else if (target_load) begin
         snap_pend <= snap_i;
      end else if (snap_fire) begin
         snap_pend <= 1'b0;
      end
   end
`else
   assign snap_fire = 1'b0;
`endif

   // The prescaler only counts while ramping; idling or snapping restarts it.
   assign pre_clear = !ramp_active(state) || snap_fire;
   assign pre_tick  = period_end && ramp_active(state);

   pwm_step_prescaler #(
      .STEP_DIV (STEP_DIV)
   ) u_prescaler (
      .clk         (clk),
      .rst         (rst),
      .clear       (pre_clear),
      .tick        (pre_tick),
      .step_strobe (step_strobe)
   );

   // Extended-width step candidates so neither direction can wrap.
   assign up_sum  = {1'b0, duty_o} + STEP_W;
   assign dn_diff = {1'b0, duty_o} - STEP_W;

   // Next duty value: clamp toward the current target. The direction comes
   // from the live comparison so a reversal never overshoots.
   always_comb begin
      duty_d = duty_o;
      if (snap_fire) begin
         duty_d = target_q;
      end else if (step_strobe) begin
         if (target_q > duty_o) begin
            if (up_sum > {1'b0, target_q}) begin
               duty_d = target_q;
            end else begin
               duty_d = up_sum[WIDTH-1:0];
            end
         end else if (target_q < duty_o) begin
            if (dn_diff[WIDTH] || (dn_diff < {1'b0, target_q})) begin
               duty_d = target_q;
            end else begin
               duty_d = dn_diff[WIDTH-1:0];
            end
         end
      end
   end

   // State follows the target against the duty value being written, so busy
   // drops on the same edge that duty_o lands on the target.
   always_comb begin
      state_d = IDLE;
      if (target_q > duty_d) begin
         state_d = UP;
      end else if (target_q < duty_d) begin
         state_d = DOWN;
      end
   end

   // Ramp FSM with registered duty, update pulse and busy flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         target_q <= '0;
         duty_o   <= '0;
         duty_upd <= 1'b0;
         busy     <= 1'b0;
      end else begin
         if (target_load) begin
            target_q <= target_i;
         end
         duty_o   <= duty_d;
         duty_upd <= (duty_d != duty_o);
         state    <= state_d;
         busy     <= ramp_active(state_d);
      end
   end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: channel A (STEP=1, STEP_DIV=2) and channel B
// (STEP=3, STEP_DIV=1) driven with directed sequences, a per-cycle reference
// model, a duty-update scoreboard and literal spot checks.
module tb_pwm_duty_ramp;
   import pwm_pkg::*;

   logic        clk;
   logic        rst;
   logic [7:0]  tgt[2];
   logic        load_s[2];
   logic        pe[2];
   logic        snap[2];
   logic [7:0]  duty[2];
   logic        upd[2];
   logic        busy[2];
   ramp_state_t st[2];

   int checks;
   int errors;

   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];

   pwm_duty_ramp #(.WIDTH(8), .STEP(1), .STEP_DIV(2)) dut_a (
      .clk         (clk),
      .rst         (rst),
      .target_i    (tgt[0]),
      .target_load (load_s[0]),
      .period_end  (pe[0]),
`ifdef PWM_RAMP_SNAP_EN
      .snap_i      (snap[0]),
`endif
      .duty_o      (duty[0]),
      .duty_upd    (upd[0]),
      .busy        (busy[0]),
      .state_dbg   (st[0])
   );

   pwm_duty_ramp #(.WIDTH(8), .STEP(3), .STEP_DIV(1)) dut_b (
      .clk         (clk),
      .rst         (rst),
      .target_i    (tgt[1]),
      .target_load (load_s[1]),
      .period_end  (pe[1]),
`ifdef PWM_RAMP_SNAP_EN
      .snap_i      (snap[1]),
`endif
      .duty_o      (duty[1]),
      .duty_upd    (upd[1]),
      .busy        (busy[1]),
      .state_dbg   (st[1])
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: target, duty, moving flag, period count, pending snap.
   int m_t[2];
   int m_d[2];
   int m_cnt[2];
   bit m_act[2];
   bit m_upd[2];
   bit m_pend[2];

   function automatic int step_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic int div_of(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   function automatic bit step_now(input int k);
      return m_act[k] && pe[k] && (m_cnt[k] == div_of(k) - 1);
   endfunction

   function automatic int next_duty(input int k);
      int d;
      int t;
      d = m_d[k];
      t = m_t[k];
      if (m_pend[k] && pe[k]) return t;
      if (!step_now(k)) return d;
      if (t > d) return (d + step_of(k) > t) ? t : d + step_of(k);
      if (t < d) return (d - step_of(k) < t) ? t : d - step_of(k);
      return d;
   endfunction

   function automatic int next_cnt(input int k);
      if (m_pend[k] && pe[k]) return 0;
      if (!m_act[k]) return 0;
      if (!pe[k]) return m_cnt[k];
      return (m_cnt[k] == div_of(k) - 1) ? 0 : m_cnt[k] + 1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            m_t[k]    <= 0;
            m_d[k]    <= 0;
            m_cnt[k]  <= 0;
            m_act[k]  <= 1'b0;
            m_upd[k]  <= 1'b0;
            m_pend[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_d[k]   <= next_duty(k);
            m_upd[k] <= (next_duty(k) != m_d[k]);
            m_act[k] <= (next_duty(k) != m_t[k]);
            m_cnt[k] <= next_cnt(k);
            if (load_s[k]) begin
               m_t[k]    <= int'(tgt[k]);
               m_pend[k] <= snap[k];
            end else if (pe[k]) begin
               m_pend[k] <= 1'b0;
            end
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (int'(duty[k]) != m_d[k] || upd[k] != m_upd[k] || busy[k] != m_act[k]) begin
               errors++;
               $display("FAIL model_ch%0d t=%0t duty=%0d upd=%0b busy=%0b expected duty=%0d upd=%0b busy=%0b",
                        k, $time, duty[k], upd[k], busy[k], m_d[k], m_upd[k], m_act[k]);
            end
         end
      end
   end

   // Scoreboard: every duty_upd pulse must deliver the next expected duty.
   always @(negedge clk) begin
      if (!rst && upd[0]) begin
         checks++;
         if (exp_q0.size() == 0) begin
            errors++;
            $display("FAIL sb_a_extra duty=%0d with nothing expected", duty[0]);
         end else if (duty[0] != exp_q0[0]) begin
            errors++;
            $display("FAIL sb_a duty=%0d expected %0d", duty[0], exp_q0[0]);
            void'(exp_q0.pop_front());
         end else begin
            void'(exp_q0.pop_front());
         end
      end
      if (!rst && upd[1]) begin
         checks++;
         if (exp_q1.size() == 0) begin
            errors++;
            $display("FAIL sb_b_extra duty=%0d with nothing expected", duty[1]);
         end else if (duty[1] != exp_q1[0]) begin
            errors++;
            $display("FAIL sb_b duty=%0d expected %0d", duty[1], exp_q1[0]);
            void'(exp_q1.pop_front());
         end else begin
            void'(exp_q1.pop_front());
         end
      end
   end

   // Driver tasks: inputs change 2 time units after a rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pe_pulse(input int ch);
      pe[ch] = 1'b1;
      tick(1);
      pe[ch] = 1'b0;
   endtask

   task automatic pe_n(input int ch, input int n, input int gap);
      repeat (n) begin
         tick(gap);
         pe_pulse(ch);
      end
   endtask

   task automatic load(input int ch, input int v, input bit s);
      tgt[ch]    = 8'(v);
      snap[ch]   = s;
      load_s[ch] = 1'b1;
      tick(1);
      load_s[ch] = 1'b0;
      snap[ch]   = 1'b0;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tgt[k] = 8'd0; load_s[k] = 1'b0; pe[k] = 1'b0; snap[k] = 1'b0;
      end
      tick(3);
      chk("reset_duty", int'(duty[0]), 0);
      chk("reset_busy", int'(busy[0]), 0);
      chk("reset_upd", int'(upd[0]), 0);
      rst = 1'b0;
      tick(2);

      // Ramp up on A: 0 -> 4, one step every second period_end.
      load(0, 4, 1'b0);
      chk("load_busy_lag", int'(busy[0]), 0);
      tick(1);
      chk("load_busy_high", int'(busy[0]), 1);
      exp_q0.push_back(8'd1); exp_q0.push_back(8'd2);
      exp_q0.push_back(8'd3); exp_q0.push_back(8'd4);
      pe_n(0, 1, 9);
      chk("first_pe_no_step", int'(duty[0]), 0);
      pe_n(0, 1, 9);
      chk("second_pe_step", int'(duty[0]), 1);
      pe_n(0, 6, 9);
      chk("ramp_up_final", int'(duty[0]), 4);
      chk("ramp_up_busy_drop", int'(busy[0]), 0);
      pe_n(0, 2, 9);
      chk("idle_hold", int'(duty[0]), 4);

      // Reset in the middle of a ramp on A (4 -> 9, stopped at 5).
      load(0, 9, 1'b0);
      tick(2);
      exp_q0.push_back(8'd5);
      pe_n(0, 3, 5);
      chk("mid_ramp_duty", int'(duty[0]), 5);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_duty", int'(duty[0]), 0);
      chk("async_rst_busy", int'(busy[0]), 0);
      chk("async_rst_upd", int'(upd[0]), 0);
      tick(3);
      rst = 1'b0;
      tick(2);
      chk("post_rst_duty", int'(duty[0]), 0);
      chk("post_rst_busy", int'(busy[0]), 0);

      // Reversal on A: ramping up at 5 toward 9 with one period banked.
      load(0, 9, 1'b0);
      tick(2);
      for (int v = 1; v <= 5; v++) exp_q0.push_back(8'(v));
      pe_n(0, 11, 3);
      chk("rev_start", int'(duty[0]), 5);
      load(0, 3, 1'b0);
      tick(2);
      chk("rev_state_down", int'(st[0]), int'(DOWN));
      exp_q0.push_back(8'd4);
      pe_pulse(0);
      chk("rev_count_kept", int'(duty[0]), 4);
      exp_q0.push_back(8'd3);
      pe_n(0, 2, 3);
      tick(1);
      chk("rev_end_duty", int'(duty[0]), 3);
      chk("rev_end_idle", int'(st[0]), int'(IDLE));
      chk("rev_end_busy", int'(busy[0]), 0);

      // Collision on A: load 0 lands on a stepping period_end while going up.
      load(0, 8, 1'b0);
      tick(2);
      pe_n(0, 1, 3);
      exp_q0.push_back(8'd4);
      tgt[0] = 8'd0; load_s[0] = 1'b1; pe[0] = 1'b1;
      tick(1);
      load_s[0] = 1'b0; pe[0] = 1'b0;
      chk("collision_old_target", int'(duty[0]), 4);
      for (int v = 3; v >= 0; v--) exp_q0.push_back(8'(v));
      pe_n(0, 8, 3);
      chk("collision_down_end", int'(duty[0]), 0);
      chk("collision_busy", int'(busy[0]), 0);

      // Clamping on B: STEP=3, a step every period_end.
      load(1, 10, 1'b0);
      tick(2);
      exp_q1.push_back(8'd3); exp_q1.push_back(8'd6);
      exp_q1.push_back(8'd9); exp_q1.push_back(8'd10);
      pe_n(1, 4, 2);
      chk("clamp_up_10", int'(duty[1]), 10);
      load(1, 2, 1'b0);
      tick(2);
      exp_q1.push_back(8'd7); exp_q1.push_back(8'd4); exp_q1.push_back(8'd2);
      pe_n(1, 3, 2);
      chk("clamp_down_2", int'(duty[1]), 2);
      load(1, 0, 1'b0);
      tick(2);
      exp_q1.push_back(8'd0);
      pe_n(1, 1, 2);
      chk("no_underflow", int'(duty[1]), 0);
      chk("no_underflow_busy", int'(busy[1]), 0);
      load(1, 254, 1'b0);
      tick(2);
      for (int v = 3; v <= 252; v += 3) exp_q1.push_back(8'(v));
      exp_q1.push_back(8'd254);
      pe_n(1, 85, 2);
      chk("clamp_up_254", int'(duty[1]), 254);
      load(1, 255, 1'b0);
      tick(2);
      exp_q1.push_back(8'd255);
      pe_pulse(1);
      chk("no_wrap_255", int'(duty[1]), 255);
      chk("no_wrap_busy", int'(busy[1]), 0);
      pe_n(1, 2, 2);
      chk("hold_255", int'(duty[1]), 255);

`ifdef PWM_RAMP_SNAP_EN
      // Snap on A: jump 0 -> 200 on the first period_end.
      load(0, 200, 1'b1);
      tick(3);
      exp_q0.push_back(8'd200);
      pe_pulse(0);
      chk("snap_duty", int'(duty[0]), 200);
      chk("snap_busy", int'(busy[0]), 0);
      // A normal load cancels a pending snap: 200 ramps to 199.
      load(0, 198, 1'b1);
      load(0, 199, 1'b0);
      tick(2);
      exp_q0.push_back(8'd199);
      pe_n(0, 2, 3);
      chk("snap_cancel", int'(duty[0]), 199);
`endif

      tick(3);
      chk("sb_a_drained", exp_q0.size(), 0);
      chk("sb_b_drained", exp_q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
